// File: rtl/gate_tt_pkg.sv
// Shared state encoding, result-bit positions and golden truth table for the gate self-test.
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int BIT_NOT_A = 0;
  localparam int BIT_NOT_B = 1;
  localparam int BIT_OR    = 2;
  localparam int BIT_AND   = 3;
  localparam int BIT_XOR   = 4;
  localparam int BIT_NOR   = 5;
  localparam int BIT_NAND  = 6;
  localparam int BIT_XNOR  = 7;

  // Indexed by vec = {a, b}.
  localparam logic [3:0][7:0] EXP_TABLE = {8'h8C, 8'h56, 8'h55, 8'hE3};

endpackage

// File: rtl/gate_tt_expected.sv
// Golden gate results for one input vector; purely combinational, no flow control.
module gate_tt_expected
  import gate_tt_pkg::*;
(
  input  logic [1:0] vec,
  output logic [7:0] expected
);

  assign expected = EXP_TABLE[vec];

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps a/b over all four vectors, checks the eight gate outputs after a settle delay.
// Each vector costs SETTLE_CYCLES+1 cycles; start is ignored while busy.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_drv,
  output logic             b_drv,
  input  logic             not_a_in,
  input  logic             not_b_in,
  input  logic             or_in,
  input  logic             and_in,
  input  logic             xor_in,
  input  logic             nor_in,
  input  logic             nand_in,
  input  logic             xnor_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_vec
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [7:0]       fail_q, fail_d;
  logic [7:0]       result_vec;
  logic [7:0]       expected;
  logic [7:0]       mism;
  logic             last_vec;

  always_comb begin
    result_vec            = '0;
    result_vec[BIT_NOT_A] = not_a_in;
    result_vec[BIT_NOT_B] = not_b_in;
    result_vec[BIT_OR]    = or_in;
    result_vec[BIT_AND]   = and_in;
    result_vec[BIT_XOR]   = xor_in;
    result_vec[BIT_NOR]   = nor_in;
    result_vec[BIT_NAND]  = nand_in;
    result_vec[BIT_XNOR]  = xnor_in;
  end

  gate_tt_expected u_expected (
    .vec      (vec_q),
    .expected (expected)
  );

  assign mism     = result_vec ^ expected;
  assign last_vec = (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SETTLE;
      SETTLE:     if (settle_q == SETTLE_LAST) state_d = CHECK;
      CHECK:      state_d = last_vec ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q      <= '0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    fail_d     = fail_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d      = '0;
          settle_d   = '0;
          pass_cnt_d = '0;
          err_d      = '0;
          fail_d     = '0;
        end
      end
      SETTLE: settle_d = settle_q + SW'(1);
      CHECK: begin
        fail_d   = fail_q | mism;
        settle_d = '0;
        if ((|mism) && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
        // On the final vector hold a/b so the board shows the last stimulus.
        if (!last_vec) begin
          vec_d = vec_q + 2'd1;
          if (vec_q == 2'd3) pass_cnt_d = pass_cnt_q + PW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state_q)
      SETTLE, CHECK: busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (err_q == '0);
      end
      default: ;
    endcase
  end

  assign a_drv     = vec_q[1];
  assign b_drv     = vec_q[0];
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Self-test stage that wraps the two-input basic-gate block.
- Upstream side: sequences the gate inputs a/b through all four combinations.
- Downstream side: samples the eight gate outputs after a settle interval, compares them to the exact truth table, and accumulates a per-gate fail mask and an error count.
- Used on the board with switches/LEDs (start on a button, pass/done on LEDs).

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling results; legal range >= 1.
- PASSES, 1, number of complete 4-vector sweeps per run; legal range >= 1.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE or DONE.
- a_drv  output  1  drives gate input a.
- b_drv  output  1  drives gate input b.
- not_a_in  input  1  gate NOT(a) result.
- not_b_in  input  1  gate NOT(b) result.
- or_in  input  1  gate OR result.
- and_in  input  1  gate AND result.
- xor_in  input  1  gate XOR result.
- nor_in  input  1  gate NOR result.
- nand_in  input  1  gate NAND result.
- xnor_in  input  1  gate XNOR result.
- busy  output  1  high in SETTLE or CHECK.
- done  output  1  high in DONE (level, held).
- pass  output  1  high in DONE when err_count == 0.
- err_count  output  ERR_W  number of mismatching vectors, saturating.
- fail_vec  output  8  sticky OR of mismatching bits, packed as result_vec.

Behaviour:
- Result packing: result_vec[7:0] = {xnor, nand, nor, xor, and, or, not_b, not_a}.
- Expected values, index vec = {a, b}: 00 -> 0xE3, 01 -> 0x55, 10 -> 0x56, 11 -> 0x8C.
- Synchronous reset: state = IDLE; a_drv = b_drv = 0; vec = 0, settle counter = 0, pass counter = 0; busy = done = pass = 0; err_count = 0; fail_vec = 0.
- Reset asserted mid-run aborts immediately to the reset state. No partial result is retained.
- IDLE:
  - start = 1 -> clear err_count and fail_vec; set vec = 0, counters = 0; go to SETTLE.
  - a_drv = vec[1], b_drv = vec[0] are registered outputs and change on the transition edge.
- SETTLE: settle counter increments each cycle. When it equals SETTLE_CYCLES-1, go to CHECK.
- CHECK (one cycle):
  - Sample the result inputs and compute mism = result_vec XOR expected[vec].
  - fail_vec |= mism.
  - If mism != 0, err_count += 1, saturating at 2^ERR_W - 1.
  - If vec == 3 and pass counter == PASSES-1 -> go to DONE.
  - Otherwise vec wraps 3 -> 0 (pass counter increments on wrap), settle counter = 0, go to SETTLE.
- Timing: each vector takes SETTLE_CYCLES+1 cycles. A run takes 4*PASSES*(SETTLE_CYCLES+1) cycles from the start-accept edge to DONE entry (12 cycles at defaults).
- DONE:
  - done = 1, pass = (err_count == 0); results are held and a_drv/b_drv hold the last vector.
  - start = 1 -> restart exactly as from IDLE, same cycle behaviour; done and pass drop on that edge.
- start while busy is ignored and has no effect on the run in progress.
- Result inputs are treated as combinational from a_drv/b_drv. With SETTLE_CYCLES >= 1 they are sampled at least one full cycle after the vector changes.

Decomposition:
- Package gate_tt_pkg:
  - state enum {IDLE, SETTLE, CHECK, DONE};
  - bit-position constants for result_vec;
  - 4-entry expected table constant (0xE3, 0x55, 0x56, 0x8C).
- Sub-module gate_tt_expected: combinational 2-bit vec -> 8-bit expected lookup, reused by the bench scoreboard.
- The FSM, counters and accumulation stay in gate_tt_checker.

Test Plan:
- Fault-free gate block, defaults, start pulse -> busy high for 12 cycles, a/b step 00, 01, 10, 11; then done = 1, pass = 1, err_count = 0, fail_vec = 0x00.
- and_in forced 0 -> mismatch only at vec 11: fail_vec = 0x08, err_count = 1, pass = 0.
- Same fault with PASSES = 2 -> err_count = 2, fail_vec = 0x08, done after 24 cycles.
- ERR_W = 2, PASSES = 2, all result inputs inverted -> 8 mismatching vectors, err_count saturates at 3, fail_vec = 0xFF.
- start re-pulsed at cycle 5 of a run -> ignored, done still after exactly 12 cycles; start in DONE -> restart, err_count and fail_vec cleared on the accept edge.
- rst asserted during CHECK of vec 10 -> next cycle all outputs at reset values and state IDLE; a subsequent start runs cleanly to pass = 1.
